// File: rtl/seq_divider64.sv
// seq_divider64 - multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   start      request a division (accepted only while ready=1)
//   dividend   unsigned dividend, sampled on the accepting edge
//   divisor    unsigned divisor, sampled on the accepting edge
//   ready      unit idle and able to accept start
//   done       one-cycle pulse, results valid
//   quotient   result quotient (held until next completion)
//   remainder  result remainder (held until next completion)
//   divByZero  last accepted divisor was zero
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready=1, waiting for start
// S_RUN  | one shift-subtract iteration per edge, WIDTH edges total
// S_DONE | done=1 for one cycle, results valid; returns to S_IDLE

module seq_divider64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  // The partial remainder is always < divisor, so its top bit is always zero
  // and only WIDTH bits are stored; the WIDTH+1 bit trial value T keeps the
  // shifted-out bit so a divisor with its MSB set cannot overflow.
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_dbz;

  logic [WIDTH:0]   w_t;
  logic [WIDTH+1:0] w_sum;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_unused_diff_msb;

  // T - {0,D} as T + ~{0,D} + 1; the extra top bit captures the carry-out.
  assign w_t         = {r_rem, r_q[WIDTH-1]};
  assign w_sum       = {1'b0, w_t} + {1'b0, ~{1'b0, r_d}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign w_no_borrow = w_sum[WIDTH+1];
  // When no borrow occurs the difference is < D, so its bit WIDTH is zero.
  assign w_unused_diff_msb = w_sum[WIDTH];
  assign w_rem_next  = w_no_borrow ? w_sum[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign w_q_next    = {r_q[WIDTH-2:0], w_no_borrow};

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_state_next = (divisor == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (r_cnt == '0) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q       <= '0;
      r_d       <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              r_quot    <= '1;
              r_rem_out <= dividend;
              r_dbz     <= 1'b1;
            end else begin
              r_q   <= dividend;
              r_d   <= divisor;
              r_rem <= '0;
              r_cnt <= CW'(WIDTH - 1);
            end
          end
        end
        S_RUN: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_quot    <= w_q_next;
            r_rem_out <= w_rem_next;
            r_dbz     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem_out;
  assign divByZero = r_dbz;

endmodule

// File: tb/tb_seq_divider64.sv
module tb_seq_divider64;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        ready;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        divByZero;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_bad;
  int hold_bad;

  seq_divider64 #(.WIDTH(64)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts edges until done is seen at a negedge. With scramble=1 start is
  // dropped and the operand inputs are disturbed after the first edge.
  task automatic wait_done(input bit scramble, output int lat);
    logic [63:0] qh, rh;
    bit          seen;
    qh = quotient;
    rh = remainder;
    lat = 0;
    seen = 0;
    busy_bad = 0;
    hold_bad = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (scramble) begin
        start    = 1'b0;
        dividend = ~dividend;
        divisor  = divisor + 64'd1;
      end
      if (done) seen = 1;
      else begin
        if (ready) busy_bad++;
        if (quotient !== qh || remainder !== rh) hold_bad++;
      end
    end
    if (!seen) lat = -1;
  endtask

  task automatic run_div(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic z, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    wait_done(1'b1, lat);
    q = quotient;
    r = remainder;
    z = divByZero;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd0);
  endtask

  logic [63:0] q, r, a, b;
  logic        z;
  int          lat;
  int          done_cnt;

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_quot", quotient, 64'd0);
    chk("rst_rem", remainder, 64'd0);
    chk("rst_dbz", {63'd0, divByZero}, 64'd0);

    // 100 / 7
    run_div(64'd100, 64'd7, q, r, z, lat);
    chk("basic_q", q, 64'd14);
    chk("basic_r", r, 64'd2);
    chk("basic_dbz", {63'd0, z}, 64'd0);
    chk("basic_lat", 64'(lat), 64'd65);
    chk("basic_busy", 64'(busy_bad), 64'd0);
    chk("basic_hold", 64'(hold_bad), 64'd0);

    // divide by zero
    run_div(64'h1234, 64'd0, q, r, z, lat);
    chk("dbz_q", q, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dbz_r", r, 64'h1234);
    chk("dbz_flag", {63'd0, z}, 64'd1);
    chk("dbz_lat", 64'(lat), 64'd1);

    run_div(64'd9, 64'd3, q, r, z, lat);
    chk("after_dbz_q", q, 64'd3);
    chk("after_dbz_r", r, 64'd0);
    chk("after_dbz_flag", {63'd0, z}, 64'd0);
    chk("after_dbz_hold", 64'(hold_bad), 64'd0);

    // extremes
    run_div(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, q, r, z, lat);
    chk("max_div1_q", q, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("max_div1_r", r, 64'd0);
    run_div(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, q, r, z, lat);
    chk("max_msb_q", q, 64'd1);
    chk("max_msb_r", r, 64'h7FFF_FFFF_FFFF_FFFF);
    run_div(64'd5, 64'd9, q, r, z, lat);
    chk("small_q", q, 64'd0);
    chk("small_r", r, 64'd5);

    // start held high through RUN and DONE
    dividend = 64'd20;
    divisor  = 64'd6;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 64'd50;
    divisor  = 64'd5;
    wait_done(1'b0, lat);
    chk("busy1_lat", 64'(lat), 64'd64);
    chk("busy1_q", quotient, 64'd3);
    chk("busy1_r", remainder, 64'd2);
    @(posedge clk);
    @(negedge clk);
    chk("busy_idle_ready", {63'd0, ready}, 64'd1);
    wait_done(1'b1, lat);
    chk("busy2_lat", 64'(lat), 64'd65);
    chk("busy2_q", quotient, 64'd10);
    chk("busy2_r", remainder, 64'd0);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // reset during RUN
    dividend = 64'd1000;
    divisor  = 64'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_ready", {63'd0, ready}, 64'd1);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_quot", quotient, 64'd0);
    chk("mid_rst_rem", remainder, 64'd0);
    done_cnt = 0;
    repeat (80) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("mid_rst_no_done", 64'(done_cnt), 64'd0);
    run_div(64'd1000, 64'd3, q, r, z, lat);
    chk("post_rst_q", q, 64'd333);
    chk("post_rst_r", r, 64'd1);

    // random operands against the language's own division
    for (int i = 0; i < 200; i++) begin
      a = {$urandom, $urandom} >> $urandom_range(63, 0);
      b = {$urandom, $urandom} >> $urandom_range(63, 0);
      if (b == 64'd0) b = 64'd1;
      run_div(a, b, q, r, z, lat);
      chk("rand_q", q, a / b);
      chk("rand_r", r, a % b);
      chk("rand_inv", q * b + r, a);
      chk("rand_rlt", {63'd0, (r < b)}, 64'd1);
      chk("rand_lat", 64'(lat), 64'd65);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
